// File: rtl/tx_pkg.sv
// Shared types and defaults for the TX word serializer.
package tx_pkg;

    localparam int unsigned TX_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        READ,
        LOAD,
        SHIFT,
        PARITY,
        NEXT,
        DONE
    } tx_ser_state_e;

endpackage

// File: rtl/tx_word_serializer_if.sv
// Buffer read port, serial link and control signals of the TX word serializer.
interface tx_word_serializer_if
    import tx_pkg::*;
#(
    parameter int unsigned DATA_W = TX_DATA_W,
    parameter int unsigned ADDR_W = 2
);

    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] last_addr;
    logic              rx_ready;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              tx_data;
    logic              tx_valid;
    logic              tx_last;
    logic              busy;
    logic              tx_finish;

    modport master (
        input  start, abort, last_addr, rx_ready, mem_rd_data,
        output mem_rd_en, mem_addr, tx_data, tx_valid, tx_last, busy, tx_finish
    );

    modport slave (
        output start, abort, last_addr, rx_ready, mem_rd_data,
        input  mem_rd_en, mem_addr, tx_data, tx_valid, tx_last, busy, tx_finish
    );

endinterface

// File: rtl/tx_shift_reg.sv
// Parallel-load shift register with a latched parity bit for one word.
module tx_shift_reg
    import tx_pkg::*;
#(
    parameter int unsigned DATA_W     = TX_DATA_W,
    parameter bit          MSB_FIRST  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              sout,
    output logic              parity_out
);

    logic [DATA_W-1:0] sreg_q;
    logic              parity_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sreg_q   <= '0;
            parity_q <= 1'b0;
        end else if (load) begin
            sreg_q   <= din;
            parity_q <= (^din) ^ PARITY_ODD;
        end else if (shift) begin
            sreg_q <= MSB_FIRST ? {sreg_q[DATA_W-2:0], 1'b0} : {1'b0, sreg_q[DATA_W-1:1]};
        end
    end

    assign sout       = MSB_FIRST ? sreg_q[DATA_W-1] : sreg_q[0];
    assign parity_out = parity_q;

endmodule

// File: rtl/tx_word_serializer.sv
// Reads words 0..last_addr from a synchronous buffer and sends each one bit-serially,
// optionally followed by a parity bit, one word per receiver-ready handshake.
module tx_word_serializer
    import tx_pkg::*;
#(
    parameter int unsigned DATA_W     = TX_DATA_W,
    parameter int unsigned ADDR_W     = 2,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input logic                  clk,
    input logic                  rst,
    tx_word_serializer_if.master bus
);

    localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    tx_ser_state_e     state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [CNT_W-1:0]  bit_cnt_inc;
    logic              mem_rd_en_q;
    logic              tx_valid_q;
    logic              tx_last_q;
    logic              busy_q;
    logic              tx_finish_q;
    logic              sout;
    logic              parity_out;
    logic              sr_load;
    logic              sr_shift;

    assign bit_cnt_inc = bit_cnt_q + 1'b1;
    assign sr_load     = (state_q == LOAD);
    assign sr_shift    = (state_q == SHIFT);

    tx_shift_reg #(
        .DATA_W     (DATA_W),
        .MSB_FIRST  (MSB_FIRST),
        .PARITY_ODD (PARITY_ODD)
    ) u_shift_reg (
        .clk        (clk),
        .rst        (rst),
        .clr        (bus.abort),
        .load       (sr_load),
        .shift      (sr_shift),
        .din        (bus.mem_rd_data),
        .sout       (sout),
        .parity_out (parity_out)
    );

    // Outputs are registered alongside the state so each one reflects the state being entered.
    always_ff @(posedge clk) begin
        if (rst || bus.abort) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            bit_cnt_q   <= '0;
            mem_rd_en_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            tx_finish_q <= 1'b0;
            if (rst) begin
                last_addr_q <= '0;
            end
        end else begin
            mem_rd_en_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            tx_finish_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q     <= WAIT_RDY;
                        last_addr_q <= bus.last_addr;
                        addr_q      <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                WAIT_RDY: begin
                    if (bus.rx_ready) begin
                        state_q     <= READ;
                        mem_rd_en_q <= 1'b1;
                    end
                end
                READ: begin
                    state_q <= LOAD;
                end
                LOAD: begin
                    state_q    <= SHIFT;
                    bit_cnt_q  <= '0;
                    tx_valid_q <= 1'b1;
                end
                SHIFT: begin
                    bit_cnt_q <= bit_cnt_inc;
                    if (bit_cnt_q == LAST_BIT) begin
                        if (PARITY_EN) begin
                            state_q    <= PARITY;
                            tx_valid_q <= 1'b1;
                            tx_last_q  <= 1'b1;
                        end else begin
                            state_q <= NEXT;
                        end
                    end else begin
                        tx_valid_q <= 1'b1;
                        tx_last_q  <= !PARITY_EN && (bit_cnt_inc == LAST_BIT);
                    end
                end
                PARITY: begin
                    state_q <= NEXT;
                end
                NEXT: begin
                    // Compare before incrementing so a full-range transfer never wraps.
                    if (addr_q == last_addr_q) begin
                        state_q     <= DONE;
                        tx_finish_q <= 1'b1;
                    end else begin
                        addr_q  <= addr_q + 1'b1;
                        state_q <= WAIT_RDY;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_rd_en = mem_rd_en_q;
    assign bus.mem_addr  = addr_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_last   = tx_last_q;
    assign bus.busy      = busy_q;
    assign bus.tx_finish = tx_finish_q;
    assign bus.tx_data   = tx_valid_q & ((state_q == PARITY) ? parity_out : sout);

endmodule

// File: tb/tb_tx_word_serializer.sv
// Bench for tx_word_serializer: four variants (plain, even parity, odd parity, MSB-first)
// run side by side on the same stimulus and are checked against a word-level model.
module tb_tx_word_serializer;
    import tx_pkg::*;

    localparam int DW = TX_DATA_W;
    localparam int AW = 2;
    localparam int NI = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          rx_ready = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] mem [4];

    logic [NI-1:0] busy_w, valid_w, data_w, last_w, fin_w, rden_w;

    int cyc = 0;
    int st_cyc = 0;
    int checks = 0;
    int failures = 0;
    int stray = 0;
    bit mon_bit [NI][64];
    bit mon_lst [NI][64];
    int mon_len [NI];
    int fin_cnt [NI];
    int rd_cnt [NI];
    int first_cyc [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        tx_word_serializer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

        tx_word_serializer #(
            .DATA_W     (DW),
            .ADDR_W     (AW),
            .PARITY_EN  (g == 1 || g == 2),
            .PARITY_ODD (g == 2),
            .MSB_FIRST  (g == 3)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.master)
        );

        assign bus.start     = start;
        assign bus.abort     = abort;
        assign bus.last_addr = last_addr;
        assign bus.rx_ready  = rx_ready;
        always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];

        assign busy_w[g]  = bus.busy;
        assign valid_w[g] = bus.tx_valid;
        assign data_w[g]  = bus.tx_data;
        assign last_w[g]  = bus.tx_last;
        assign fin_w[g]   = bus.tx_finish;
        assign rden_w[g]  = bus.mem_rd_en;
    end

    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (valid_w[g] === 1'b1) begin
                if (mon_len[g] < 64) begin
                    mon_bit[g][mon_len[g]] = data_w[g];
                    mon_lst[g][mon_len[g]] = last_w[g];
                end
                if (first_cyc[g] < 0) first_cyc[g] = cyc;
                mon_len[g]++;
            end
            if (fin_w[g] === 1'b1) fin_cnt[g]++;
            if (rden_w[g] === 1'b1) rd_cnt[g]++;
            if ((last_w[g] === 1'b1 || data_w[g] === 1'b1) && valid_w[g] !== 1'b1) stray++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        for (int g = 0; g < NI; g++) begin
            mon_len[g] = 0;
            fin_cnt[g] = 0;
            rd_cnt[g] = 0;
            first_cyc[g] = -1;
        end
    endtask

    task automatic fill_mem_random();
        for (int i = 0; i < 4; i++) mem[i] = DW'($urandom);
    endtask

    // Captured last_addr must be used, so scramble the port right after the start cycle.
    task automatic pulse_start(input int last);
        last_addr = AW'(last);
        start = 1'b1;
        st_cyc = cyc;
        step();
        start = 1'b0;
        last_addr = AW'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy_w !== '0 && n < 500) begin
            step();
            n++;
        end
        checks++;
        if (busy_w !== '0) begin
            failures++;
            $display("FAIL %s timeout: busy=%b required %b", name, busy_w, 4'b0000);
        end
        step();
    endtask

    // Expected stream: words 0..last, each as DW data bits in link order plus optional parity.
    task automatic check_stream(input string name, input int last);
        bit            par_en, odd, msb, eb, el;
        int            wlen, bad, idx;
        logic [DW-1:0] wd;
        for (int g = 0; g < NI; g++) begin
            par_en = (g == 1 || g == 2);
            odd = (g == 2);
            msb = (g == 3);
            wlen = DW + (par_en ? 1 : 0);
            checks++;
            if (mon_len[g] != (last + 1) * wlen) begin
                failures++;
                $display("FAIL %s len inst%0d: got %0d bits required %0d", name, g, mon_len[g],
                         (last + 1) * wlen);
            end else begin
                bad = -1;
                for (int w = 0; w <= last; w++) begin
                    wd = mem[w];
                    for (int b = 0; b < wlen; b++) begin
                        idx = w * wlen + b;
                        if (b < DW) begin
                            eb = msb ? wd[DW-1-b] : wd[b];
                            el = !par_en && (b == DW - 1);
                        end else begin
                            eb = (($countones(wd) % 2) == 1) ^ odd;
                            el = 1'b1;
                        end
                        if (bad < 0 && (mon_bit[g][idx] !== eb || mon_lst[g][idx] !== el)) begin
                            bad = idx;
                            $display("FAIL %s bits inst%0d idx%0d: got data=%0b last=%0b required data=%0b last=%0b",
                                     name, g, idx, mon_bit[g][idx], mon_lst[g][idx], eb, el);
                        end
                    end
                end
                if (bad >= 0) failures++;
            end
            checks++;
            if (fin_cnt[g] != 1) begin
                failures++;
                $display("FAIL %s finish inst%0d: got %0d pulses required 1", name, g, fin_cnt[g]);
            end
            checks++;
            if (rd_cnt[g] != last + 1) begin
                failures++;
                $display("FAIL %s reads inst%0d: got %0d required %0d", name, g, rd_cnt[g], last + 1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        checks++;
        if (busy_w !== '0) begin
            failures++;
            $display("FAIL reset_busy: got %b required 0000", busy_w);
        end
        checks++;
        if ({valid_w, last_w, fin_w, rden_w} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0", {valid_w, last_w, fin_w, rden_w});
        end
        checks++;
        if (data_w !== '0) begin
            failures++;
            $display("FAIL reset_data: got %b required 0000", data_w);
        end
        rst = 1'b0;
        step();
        checks++;
        if (busy_w !== '0) begin
            failures++;
            $display("FAIL idle_after_reset: got %b required 0000", busy_w);
        end
        // Reset in the middle of a transfer.
        fill_mem_random();
        clear_mon();
        rx_ready = 1'b1;
        pulse_start(3);
        repeat (8) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({busy_w, valid_w} !== '0) begin
            failures++;
            $display("FAIL reset_mid: got busy=%b valid=%b required 0000/0000", busy_w, valid_w);
        end
        repeat (20) step();
        checks++;
        if (fin_cnt[0] + fin_cnt[1] + fin_cnt[2] + fin_cnt[3] != 0 || busy_w !== '0) begin
            failures++;
            $display("FAIL reset_mid_finish: got %0d pulses busy=%b required 0 and 0000",
                     fin_cnt[0] + fin_cnt[1] + fin_cnt[2] + fin_cnt[3], busy_w);
        end
    endtask

    task automatic test_stream();
        mem[0] = 8'hA5;
        mem[1] = 8'h3C;
        mem[2] = 8'hFF;
        mem[3] = 8'h00;
        rx_ready = 1'b1;
        clear_mon();
        pulse_start(3);
        wait_idle("stream");
        check_stream("stream", 3);
        for (int g = 0; g < NI; g++) begin
            checks++;
            if (first_cyc[g] - st_cyc != 4) begin
                failures++;
                $display("FAIL latency inst%0d: got %0d cycles required 4", g, first_cyc[g] - st_cyc);
            end
        end
    endtask

    task automatic test_parity_msb();
        fill_mem_random();
        mem[0] = 8'h07;
        rx_ready = 1'b1;
        clear_mon();
        pulse_start(0);
        wait_idle("parity07");
        check_stream("parity07", 0);
        checks++;
        if (mon_bit[1][8] !== 1'b1 || mon_bit[2][8] !== 1'b0) begin
            failures++;
            $display("FAIL parity07_bit: got even=%0b odd=%0b required 1/0", mon_bit[1][8], mon_bit[2][8]);
        end
        mem[0] = 8'h80;
        clear_mon();
        pulse_start(0);
        wait_idle("msb80");
        check_stream("msb80", 0);
        checks++;
        if (mon_bit[3][0] !== 1'b1 || mon_lst[3][7] !== 1'b1 || mon_bit[0][7] !== 1'b1) begin
            failures++;
            $display("FAIL msb80_order: got msb_first=%0b last8=%0b lsb_last=%0b required 1/1/1",
                     mon_bit[3][0], mon_lst[3][7], mon_bit[0][7]);
        end
    endtask

    task automatic test_rx_gating();
        fill_mem_random();
        rx_ready = 1'b0;
        clear_mon();
        pulse_start(1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ((rden_w | valid_w) !== '0) begin
                failures++;
                $display("FAIL rx_hold cycle%0d: got rd_en=%b valid=%b required 0000", i, rden_w, valid_w);
            end
            step();
        end
        rx_ready = 1'b1;
        step();
        checks++;
        if (rden_w !== 4'b1111) begin
            failures++;
            $display("FAIL rx_release: got rd_en=%b required 1111", rden_w);
        end
        wait_idle("rx_gate");
        check_stream("rx_gate", 1);
    endtask

    task automatic test_abort();
        int n, guard;
        fill_mem_random();
        rx_ready = 1'b1;
        clear_mon();
        pulse_start(3);
        n = 0;
        guard = 0;
        while (n < DW + 3 && guard < 200) begin
            step();
            guard++;
            if (valid_w[0] === 1'b1) n++;
        end
        checks++;
        if (n != DW + 3) begin
            failures++;
            $display("FAIL abort_reach: got %0d bits required %0d", n, DW + 3);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if ({busy_w, valid_w} !== '0) begin
            failures++;
            $display("FAIL abort_stop: got busy=%b valid=%b required 0000/0000", busy_w, valid_w);
        end
        repeat (20) step();
        checks++;
        if (fin_cnt[0] + fin_cnt[1] + fin_cnt[2] + fin_cnt[3] != 0 || mon_len[0] != DW + 3) begin
            failures++;
            $display("FAIL abort_drop: got finish=%0d bits=%0d required 0 and %0d",
                     fin_cnt[0] + fin_cnt[1] + fin_cnt[2] + fin_cnt[3], mon_len[0], DW + 3);
        end
        for (int i = 0; i < DW + 3; i++) begin
            checks++;
            if (mon_bit[0][i] !== mem[i / DW][i % DW]) begin
                failures++;
                $display("FAIL abort_prefix idx%0d: got %0b required %0b", i, mon_bit[0][i],
                         mem[i / DW][i % DW]);
            end
        end
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        step();
        checks++;
        if (busy_w !== '0) begin
            failures++;
            $display("FAIL start_abort: got busy=%b required 0000", busy_w);
        end
        clear_mon();
        pulse_start(3);
        wait_idle("after_abort");
        check_stream("after_abort", 3);
    endtask

    task automatic test_one_word();
        fill_mem_random();
        rx_ready = 1'b1;
        clear_mon();
        pulse_start(0);
        repeat (5) step();
        last_addr = 2'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle("one_word");
        check_stream("one_word", 0);
        repeat (3) step();
        checks++;
        if (busy_w !== '0 || mon_len[0] != DW) begin
            failures++;
            $display("FAIL one_word_ignore: got busy=%b bits=%0d required 0000 and %0d",
                     busy_w, mon_len[0], DW);
        end
    endtask

    task automatic test_random();
        int last, n;
        for (int it = 0; it < 12; it++) begin
            fill_mem_random();
            last = int'($urandom_range(0, 3));
            rx_ready = 1'($urandom_range(0, 1));
            clear_mon();
            pulse_start(last);
            n = 0;
            while (busy_w !== '0 && n < 1000) begin
                rx_ready = 1'($urandom_range(0, 1));
                start = (busy_w == 4'b1111) && ($urandom_range(0, 7) == 0);
                last_addr = AW'($urandom);
                step();
                n++;
            end
            start = 1'b0;
            checks++;
            if (busy_w !== '0) begin
                failures++;
                $display("FAIL random%0d timeout: busy=%b required 0000", it, busy_w);
            end
            step();
            check_stream($sformatf("random%0d", it), last);
        end
    endtask

    initial begin
        fill_mem_random();
        clear_mon();
        test_reset();
        test_stream();
        test_parity_msb();
        test_rx_gating();
        test_abort();
        test_one_word();
        test_random();
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL stray_outputs: got %0d cycles with tx_data/tx_last outside tx_valid required 0",
                     stray);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
